// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment bus: filters the scan lines,
// decodes every accepted digit and publishes a complete 8-digit frame per scan.
module seg7_scan_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter int STABLE_CYCLES  = 4,
  parameter int FRAME_TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [7:0]  an_in,
  output logic [39:0] digits_out,
  output logic        frame_valid,
  output logic        scan_err,
  output logic        pat_err,
  output logic        timeout
);

  localparam logic [6:0]    SEG_IDLE   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0]    AN_IDLE    = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
  localparam int            TW         = $clog2(FRAME_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(FRAME_TIMEOUT - 1);
  localparam logic [39:0]   ALL_BLANK  = {8{5'h10}};

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  logic [6:0]    r_seg_raw;
  logic [7:0]    r_an_raw;
  logic [6:0]    w_seg;
  logic [7:0]    w_an;
  logic [14:0]   r_prev;
  logic [7:0]    r_stab_cnt;
  logic [7:0]    w_stab_next;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_capture;
  logic          w_multi;
  logic [4:0]    w_code;
  logic [7:0]    r_mask;
  logic [4:0]    r_shadow [8];
  logic [39:0]   w_shadow_flat;
  logic [TW-1:0] r_tmo_cnt;
  logic [TW-1:0] w_tmo_inc;
  logic          w_frame_done;
  logic          w_tmo_fire;
  logic [7:0]    w_mask_base;

  function automatic logic [4:0] f_decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h00;
      7'h06: return 5'h01;
      7'h5B: return 5'h02;
      7'h4F: return 5'h03;
      7'h66: return 5'h04;
      7'h6D: return 5'h05;
      7'h7D: return 5'h06;
      7'h07: return 5'h07;
      7'h7F: return 5'h08;
      7'h6F: return 5'h09;
      7'h77: return 5'h0A;
      7'h7C: return 5'h0B;
      7'h39: return 5'h0C;
      7'h5E: return 5'h0D;
      7'h79: return 5'h0E;
      7'h71: return 5'h0F;
      7'h00: return 5'h10;
      7'h40: return 5'h11;
      default: return 5'h1F;
    endcase
  endfunction

  // Pins are registered once, idling at the inactive level of each bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_raw <= SEG_IDLE;
      r_an_raw  <= AN_IDLE;
    end else begin
      r_seg_raw <= seg_in;
      r_an_raw  <= an_in;
    end
  end

  assign w_seg = SEG_ACTIVE_LOW ? ~r_seg_raw : r_seg_raw;
  assign w_an  = AN_ACTIVE_LOW ? ~r_an_raw : r_an_raw;

  always_comb begin
    w_stab_next = r_stab_cnt;
    if ({w_an, w_seg} != r_prev) begin
      w_stab_next = 8'd1;
    end else if (r_stab_cnt < STABLE_MAX) begin
      w_stab_next = r_stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_prev     <= {w_an, w_seg};
      r_stab_cnt <= w_stab_next;
    end
  end

  // HOLD can only be left through a counter restart, so each dwell is accepted once
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_multi      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_stab_next == STABLE_MAX && w_an != 8'h00) begin
          w_state_next = ST_HOLD;
          if ($onehot(w_an)) begin
            w_capture = 1'b1;
          end else begin
            w_multi = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_stab_next != STABLE_MAX) begin
          w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  assign w_code       = f_decode(w_seg);
  assign w_frame_done = (r_mask == 8'hFF);
  assign w_tmo_inc    = r_tmo_cnt + 1'b1;
  assign w_tmo_fire   = !w_frame_done && (w_tmo_inc == TMO_LAST);
  assign w_mask_base  = (w_frame_done || w_tmo_fire) ? 8'h00 : r_mask;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_flat
      assign w_shadow_flat[5*gi +: 5] = r_shadow[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= 5'h10;
    end else if (w_capture) begin
      for (int i = 0; i < 8; i++) begin
        if (w_an[i]) r_shadow[i] <= w_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT;
      r_mask      <= '0;
      r_tmo_cnt   <= '0;
      digits_out  <= ALL_BLANK;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
      pat_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mask      <= w_mask_base | (w_capture ? w_an : 8'h00);
      r_tmo_cnt   <= (w_frame_done || w_tmo_fire) ? '0 : w_tmo_inc;
      frame_valid <= w_frame_done;
      timeout     <= w_tmo_fire;
      scan_err    <= w_multi;
      pat_err     <= w_capture && (w_code == 5'h1F);
      if (w_frame_done) digits_out <= w_shadow_flat;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a slot/mask model of the scan protocol.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam logic [39:0] BLANK = 40'h8421084210;
  localparam logic [6:0] DIGIT_PAT [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                                            7'h00, 7'h40};

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [6:0]  seg_in;
  logic [7:0]  an_in;
  logic [39:0] digits_out, t_digits_out;
  logic        frame_valid, scan_err, pat_err, timeout;
  logic        t_frame_valid, t_scan_err, t_pat_err, t_timeout;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
                      .STABLE_CYCLES(S), .FRAME_TIMEOUT(65536)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .frame_valid(frame_valid), .scan_err(scan_err),
    .pat_err(pat_err), .timeout(timeout));

  seg7_scan_decoder #(.SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
                      .STABLE_CYCLES(S), .FRAME_TIMEOUT(64)) dut_t (
    .clk(clk), .rst_n(rst2_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(t_digits_out), .frame_valid(t_frame_valid), .scan_err(t_scan_err),
    .pat_err(t_pat_err), .timeout(t_timeout));

  int errors = 0;
  int checks = 0;

  // Model: a slot per digit plus a "seen" mask; a full mask emits one expected frame
  logic [4:0]  ref_slot [8];
  logic [7:0]  ref_mask = 8'h00;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int exp_pe = 0;
  int fv_cnt = 0, se_cnt = 0, pe_cnt = 0, to_cnt = 0, dout_bad = 0;
  logic [39:0] prev_dout = BLANK;
  logic [6:0]  pats [8];

  function automatic logic [4:0] ref_code(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (DIGIT_PAT[i] == p) return 5'(i);
    if (p == 7'h00) return 5'h10;
    if (p == 7'h40) return 5'h11;
    return 5'h1F;
  endfunction

  function automatic void model_capture(input int slot, input logic [6:0] p);
    logic [39:0] frame;
    ref_slot[slot] = ref_code(p);
    if (ref_slot[slot] == 5'h1F) exp_pe++;
    ref_mask[slot] = 1'b1;
    if (ref_mask == 8'hFF) begin
      for (int i = 0; i < 8; i++) frame[5*i +: 5] = ref_slot[i];
      exp_q.push_back(frame);
      ref_mask = 8'h00;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_valid) begin
        fv_cnt++;
        got_q.push_back(digits_out);
        $display("frame %0d: digits_out=%h", fv_cnt, digits_out);
      end else if (digits_out !== prev_dout) begin
        dout_bad++;
      end
      se_cnt += int'(scan_err);
      pe_cnt += int'(pat_err);
      to_cnt += int'(timeout);
    end
    prev_dout = digits_out;
  end

  task automatic idle(input int n);
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int slot, input logic [6:0] p, input int n);
    an_in  = ~(8'h01 << slot);
    seg_in = ~p;
    repeat (n) @(negedge clk);
    if (n >= S) model_capture(slot, p);
  endtask

  task automatic scan_frame(input int dwell, input int gap);
    for (int i = 0; i < 8; i++) begin
      show(i, pats[i], dwell);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    an_in  = 8'($urandom);
    seg_in = 7'($urandom);
    repeat (2) @(negedge clk);
    ref_mask = 8'h00;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    an_in  = 8'hFF;
    seg_in = 7'h7F;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    an_in = 8'hA5; seg_in = 7'h2A;
    repeat (2) @(negedge clk);
    checks++; if (digits_out !== BLANK) begin errors++; $display("FAIL reset_digits: got %h want %h", digits_out, BLANK); end
    checks++; if ({frame_valid, scan_err, pat_err, timeout} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {frame_valid, scan_err, pat_err, timeout}); end
    checks++; if (t_digits_out !== BLANK || {t_frame_valid, t_timeout} !== 2'b0) begin errors++; $display("FAIL reset_tmo_dut: got %h/%b", t_digits_out, {t_frame_valid, t_timeout}); end
    rst_n = 1'b1; rst2_n = 1'b1;
    idle(3);
    $display("test_reset done");
  endtask

  task automatic test_scan_123();
    int fv0 = fv_cnt, ex0 = exp_q.size(), pe0 = pe_cnt;
    pats = '{7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    scan_frame(20, 2);
    idle(S + 4);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL scan123_frames: got %0d want 1", fv_cnt - fv0); end
    checks++; if (digits_out !== 40'h0000000443) begin errors++; $display("FAIL scan123_digits: got %h want 0000000443", digits_out); end
    checks++; if (exp_q.size() - ex0 != 1 || digits_out !== exp_q[$]) begin errors++; $display("FAIL scan123_model: got %h want %h", digits_out, exp_q[$]); end
    checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL scan123_paterr: got %0d want %0d", pe_cnt, pe0); end
  endtask

  task automatic test_minus_blank();
    int fv0 = fv_cnt, pe0 = pe_cnt;
    logic [39:0] want = {{5{5'h10}}, 5'h11, 5'h05, 5'h04};
    pats = '{7'h66, 7'h6D, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    scan_frame(20, 2);
    idle(S + 4);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL minus_frames: got %0d want 1", fv_cnt - fv0); end
    checks++; if (digits_out !== want) begin errors++; $display("FAIL minus_digits: got %h want %h", digits_out, want); end
    checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL minus_paterr: got %0d want %0d", pe_cnt, pe0); end
  endtask

  task automatic test_glitch();
    int fv0 = fv_cnt;
    for (int i = 0; i < 3; i++) begin show(i, 7'h07, 12); idle(2); end
    show(3, 7'h06, 15);
    show(3, 7'h7F, 2);
    show(3, 7'h06, 3);
    idle(2);
    for (int i = 4; i < 8; i++) begin show(i, 7'h6F, 12); idle(2); end
    idle(S + 4);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL glitch_frames: got %0d want 1", fv_cnt - fv0); end
    checks++; if (digits_out[15 +: 5] !== 5'h01) begin errors++; $display("FAIL glitch_digit3: got %h want 01", digits_out[15 +: 5]); end
    checks++; if (digits_out !== exp_q[$]) begin errors++; $display("FAIL glitch_model: got %h want %h", digits_out, exp_q[$]); end
  endtask

  task automatic test_scan_err();
    int fv0 = fv_cnt, se0 = se_cnt, pe0 = pe_cnt, xpe0 = exp_pe;
    an_in = 8'b1111_1100; seg_in = ~7'h06;
    repeat (10) @(negedge clk);
    idle(2);
    checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL scanerr_pulses: got %0d want 1", se_cnt - se0); end
    for (int i = 2; i < 8; i++) begin show(i, 7'h79, 10); idle(2); end
    idle(S + 4);
    checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL scanerr_mask: got %0d frames want 0", fv_cnt - fv0); end
    show(0, 7'h55, 10); idle(2);
    show(1, 7'h39, 10); idle(S + 4);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL scanerr_frame: got %0d want 1", fv_cnt - fv0); end
    checks++; if (pe_cnt - pe0 !== exp_pe - xpe0 || pe_cnt - pe0 !== 1) begin errors++; $display("FAIL paterr_pulses: got %0d want 1", pe_cnt - pe0); end
    checks++; if (digits_out[4:0] !== 5'h1F) begin errors++; $display("FAIL paterr_digit0: got %h want 1f", digits_out[4:0]); end
    checks++; if (digits_out !== exp_q[$]) begin errors++; $display("FAIL scanerr_model: got %h want %h", digits_out, exp_q[$]); end
  endtask

  task automatic test_latency();
    int lat = -1;
    for (int i = 0; i < 7; i++) begin show(i, DIGIT_PAT[i], 8); idle(2); end
    an_in = ~8'h80; seg_in = ~7'h77;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (frame_valid) begin lat = k; break; end
    end
    model_capture(7, 7'h77);
    @(negedge clk);
    idle(4);
    checks++; if (lat !== S + 2) begin errors++; $display("FAIL frame_latency: got %0d want %0d", lat, S + 2); end
    checks++; if (digits_out !== exp_q[$]) begin errors++; $display("FAIL latency_model: got %h want %h", digits_out, exp_q[$]); end
  endtask

  task automatic test_random();
    int ex0 = exp_q.size(), g0 = got_q.size(), pe0 = pe_cnt, xpe0 = exp_pe;
    int iter = 0, n_exp, n_got;
    logic [6:0] p;
    while (exp_q.size() - ex0 < 3 && iter < 600) begin
      iter++;
      p = ($urandom_range(0, 9) < 8) ? DIGIT_PAT[$urandom_range(0, 17)] : 7'($urandom);
      show($urandom_range(0, 7), p, $urandom_range(S - 2, S + 8));
      idle($urandom_range(1, 3));
    end
    idle(S + 4);
    n_exp = exp_q.size() - ex0;
    n_got = got_q.size() - g0;
    checks++; if (n_got !== n_exp) begin errors++; $display("FAIL random_frames: got %0d want %0d", n_got, n_exp); end
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      checks++; if (got_q[g0 + i] !== exp_q[ex0 + i]) begin errors++; $display("FAIL random_frame%0d: got %h want %h", i, got_q[g0 + i], exp_q[ex0 + i]); end
    end
    checks++; if (pe_cnt - pe0 !== exp_pe - xpe0) begin errors++; $display("FAIL random_paterr: got %0d want %0d", pe_cnt - pe0, exp_pe - xpe0); end
  endtask

  task automatic test_reset_midscan();
    int fv0;
    for (int i = 0; i < 6; i++) begin show(i, 7'h5E, 8); idle(2); end
    do_reset();
    fv0 = fv_cnt;
    show(6, 7'h71, 8); idle(2);
    show(7, 7'h7C, 8); idle(S + 4);
    checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL midscan_discard: got %0d frames want 0", fv_cnt - fv0); end
    checks++; if (digits_out !== BLANK) begin errors++; $display("FAIL midscan_blank: got %h want %h", digits_out, BLANK); end
    pats = '{7'h7D, 7'h4F, 7'h40, 7'h6D, 7'h00, 7'h77, 7'h3F, 7'h06};
    scan_frame(8, 2);
    idle(S + 4);
    checks++; if (fv_cnt - fv0 !== 1 || digits_out !== exp_q[$]) begin errors++; $display("FAIL midscan_frame: got %h want %h", digits_out, exp_q[$]); end
  endtask

  task automatic test_timeout();
    int first_to = -1, n_to = 0, t_fv = 0, fv0;
    int to_edges[$];
    do_reset();
    fv0 = fv_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) begin show(i, DIGIT_PAT[i + 3], 8); idle(2); end
        idle(20);
        for (int i = 5; i < 8; i++) begin show(i, DIGIT_PAT[i], 8); idle(2); end
        idle(30);
      end
      begin
        for (int k = 1; k <= 130; k++) begin
          @(posedge clk); #1;
          if (t_timeout) begin n_to++; to_edges.push_back(k); if (first_to < 0) first_to = k; end
          if (t_frame_valid) t_fv++;
        end
      end
    join
    checks++; if (first_to !== 63) begin errors++; $display("FAIL timeout_first: got %0d want 63", first_to); end
    checks++; if (n_to !== 2 || to_edges[$] !== 126) begin errors++; $display("FAIL timeout_period: got %0d pulses last %0d want 2 last 126", n_to, to_edges[$]); end
    checks++; if (t_fv !== 0) begin errors++; $display("FAIL timeout_noframe: got %0d want 0", t_fv); end
    checks++; if (t_digits_out !== BLANK) begin errors++; $display("FAIL timeout_held: got %h want %h", t_digits_out, BLANK); end
    checks++; if (fv_cnt - fv0 !== 1 || digits_out !== exp_q[$]) begin errors++; $display("FAIL timeout_main_frame: got %h want %h", digits_out, exp_q[$]); end
    checks++; if (to_cnt !== 0) begin errors++; $display("FAIL main_no_timeout: got %0d want 0", to_cnt); end
  endtask

  task automatic test_digits_stable();
    checks++; if (dout_bad !== 0) begin errors++; $display("FAIL digits_only_on_frame: got %0d stray changes want 0", dout_bad); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    an_in = 8'hFF; seg_in = 7'h7F;
    for (int i = 0; i < 8; i++) ref_slot[i] = 5'h10;
    test_reset();
    test_scan_123();
    test_minus_blank();
    test_glitch();
    test_scan_err();
    test_latency();
    test_random();
    test_reset_midscan();
    test_timeout();
    test_digits_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
